// File: rtl/clk_wiz_lock_pkg.sv
// clk_wiz_lock_pkg: state encoding and counter sizing shared by the MMCM lock controller.
package clk_wiz_lock_pkg;
  typedef logic [2:0] state_t;
  localparam state_t RESET_MMCM = 3'd0;
  localparam state_t WAIT_LOCK  = 3'd1;
  localparam state_t STABLE     = 3'd2;
  localparam state_t RUN        = 3'd3;
  localparam state_t FAULT      = 3'd4;
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction
endpackage

// File: rtl/clk_wiz_lock_ctrl_sync_bit.sv
// sync_bit: STAGES-deep flop chain bringing an asynchronous bit into the clk_i domain.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] ff_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) ff_q <= '0;
    else ff_q <= {ff_q[STAGES-2:0], d_i};
  assign q_o = ff_q[STAGES-1];
endmodule

// File: rtl/clk_wiz_lock_ctrl.sv
// clk_wiz_lock_ctrl: drives MMCM reset, qualifies lock, releases system reset, retries on timeout.
// Define LOCK_LOSS_CNT_EN to build the saturating lock-loss counter; otherwise lock_loss_cnt is 0.
module clk_wiz_lock_ctrl
  import clk_wiz_lock_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int MMCM_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT    = 1000000,
  parameter int STABLE_CYCLES   = 256,
  parameter int MAX_RETRY       = 3,
  parameter int CNT_W           = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             locked,
  output logic             mmcm_rst_n,
  output logic             rst_out_n,
  output logic             lock_ok,
  output logic             timeout_err,
  output logic [CNT_W-1:0] lock_loss_cnt
);
  localparam int CW = cnt_width(MMCM_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int RW = $clog2(MAX_RETRY + 1);
  logic          locked_s;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d, retry_inc;
  logic          mmcm_q, mmcm_d, rst_out_q, rst_out_d, ok_q, ok_d, terr_q, terr_d;
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i (sys_clk),
    .rst_ni(sys_rst_n),
    .d_i   (locked),
    .q_o   (locked_s)
  );
  assign retry_inc = retry_q + RW'(1);
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    retry_d   = retry_q;
    mmcm_d    = mmcm_q;
    rst_out_d = rst_out_q;
    ok_d      = ok_q;
    terr_d    = terr_q;
    case (state_q)
      RESET_MMCM: if (cnt_q == CW'(MMCM_RST_CYCLES - 1)) begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
        mmcm_d  = 1'b1;
      end
      WAIT_LOCK: if (locked_s) begin
        state_d = STABLE;
        cnt_d   = '0;
      end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
        retry_d = retry_inc;
        state_d = (retry_inc < RW'(MAX_RETRY)) ? RESET_MMCM : FAULT;
        terr_d  = !(retry_inc < RW'(MAX_RETRY));
        cnt_d   = '0;
        mmcm_d  = 1'b0;
      end
      // a glitch only restarts the stability window; retries are for timeouts
      STABLE: if (!locked_s) begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
        state_d   = RUN;
        cnt_d     = '0;
        retry_d   = '0;
        rst_out_d = 1'b1;
        ok_d      = 1'b1;
      end
      RUN: begin
        cnt_d = '0;
        if (!locked_s) begin
          state_d   = RESET_MMCM;
          mmcm_d    = 1'b0;
          rst_out_d = 1'b0;
          ok_d      = 1'b0;
        end
      end
      default: begin
        state_d   = FAULT;
        cnt_d     = cnt_q;
        mmcm_d    = 1'b0;
        rst_out_d = 1'b0;
        ok_d      = 1'b0;
        terr_d    = 1'b1;
      end
    endcase
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state_q   <= RESET_MMCM;
      cnt_q     <= '0;
      retry_q   <= '0;
      mmcm_q    <= 1'b0;
      rst_out_q <= 1'b0;
      ok_q      <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      mmcm_q    <= mmcm_d;
      rst_out_q <= rst_out_d;
      ok_q      <= ok_d;
      terr_q    <= terr_d;
    end
  assign mmcm_rst_n  = mmcm_q;
  assign rst_out_n   = rst_out_q;
  assign lock_ok     = ok_q;
  assign timeout_err = terr_q;
`ifdef LOCK_LOSS_CNT_EN
  logic [CNT_W-1:0] loss_q;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) loss_q <= '0;
    else if (state_q == RUN && !locked_s && loss_q != '1) loss_q <= loss_q + CNT_W'(1);
  assign lock_loss_cnt = loss_q;
`else
  assign lock_loss_cnt = '0;
`endif
endmodule

// File: tb/tb_clk_wiz_lock_ctrl.sv
// tb_clk_wiz_lock_ctrl: scoreboard bench; stimulus queues timed output changes, a monitor checks them.
module tb_clk_wiz_lock_ctrl;
`ifdef LOCK_LOSS_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  logic       sys_clk = 1'b0;
  logic       sys_rst_n, locked;
  logic       mmcm_rst_n, rst_out_n, lock_ok, timeout_err;
  logic [7:0] lock_loss_cnt;
  logic [11:0] outs;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int exp_loss = 0;
  int c, a;
  typedef struct {int cyc; logic [11:0] vec; string name;} exp_t;
  exp_t sb[$];

  clk_wiz_lock_ctrl #(
    .SYNC_STAGES(2), .MMCM_RST_CYCLES(4), .LOCK_TIMEOUT(32),
    .STABLE_CYCLES(8), .MAX_RETRY(2), .CNT_W(8)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .locked       (locked),
    .mmcm_rst_n   (mmcm_rst_n),
    .rst_out_n    (rst_out_n),
    .lock_ok      (lock_ok),
    .timeout_err  (timeout_err),
    .lock_loss_cnt(lock_loss_cnt)
  );

  assign outs = {mmcm_rst_n, rst_out_n, lock_ok, timeout_err, lock_loss_cnt};
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  function automatic logic [11:0] vv(input logic m, input logic r, input logic o, input logic t, input int l);
    return {m, r, o, t, 8'(l)};
  endfunction

  task automatic push(input int cy, input string n, input logic [11:0] v);
    exp_t e;
    e.cyc = cy; e.vec = v; e.name = n;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic chk(input string n, input logic [11:0] act, input logic [11:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", n, act, exp);
    end
  endtask

  // monitor: every change of the output vector must match the next queued expectation, at its cycle
  initial begin
    logic [11:0] prev;
    exp_t e;
    prev = '0;
    forever begin
      @(posedge sys_clk);
      #1;
      if (outs !== prev) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_change: cyc=%0d got %h, expected no change", cyc, outs);
        end else begin
          e = sb.pop_front();
          if (e.cyc != cyc || e.vec !== outs) begin
            fails++;
            $display("FAIL %s: got cyc=%0d val=%h, expected cyc=%0d val=%h", e.name, cyc, outs, e.cyc, e.vec);
          end
        end
        prev = outs;
      end
    end
  end

  initial begin
    sys_rst_n = 1'b0;
    locked    = 1'b0;
    step(3);
    chk("reset_state", outs, '0);
    // bring-up: locked rises 10 cycles after release
    c = cyc; sys_rst_n = 1'b1;
    push(c + 4, "bringup_mmcm_release", vv(1, 0, 0, 0, 0));
    step(10); locked = 1'b1;
    push(cyc + 11, "bringup_run", vv(1, 1, 1, 0, 0));
    step(13);
    chk("bringup_run_direct", outs, vv(1, 1, 1, 0, 0));
    // lock drops in RUN, recovering each time; counter saturates
    for (int i = 0; i < 260; i++) begin
      a = cyc; locked = 1'b0;
      exp_loss = CNT_EN ? ((exp_loss == 255) ? 255 : exp_loss + 1) : 0;
      push(a + 3,  "drop_rst_fall",  vv(0, 0, 0, 0, exp_loss));
      push(a + 7,  "drop_mmcm_rise", vv(1, 0, 0, 0, exp_loss));
      push(a + 16, "drop_run",       vv(1, 1, 1, 0, exp_loss));
      step(1); locked = 1'b1;
      step(19);
      if (i == 2) chk("loss_cnt_after_3", 12'(lock_loss_cnt), 12'(exp_loss));
    end
    chk("loss_cnt_saturated", 12'(lock_loss_cnt), 12'(exp_loss));
    // reset from RUN clears everything including the loss counter
    a = cyc; sys_rst_n = 1'b0; locked = 1'b0; exp_loss = 0;
    push(a + 1, "reset_from_run", '0);
    step(3);
    chk("reset_clears_all", outs, '0);
    // glitch in STABLE after 5 stable cycles restarts the window
    c = cyc; sys_rst_n = 1'b1;
    push(c + 4, "glitch_mmcm_release", vv(1, 0, 0, 0, 0));
    push(c + 24, "glitch_run", vv(1, 1, 1, 0, 0));
    step(5); locked = 1'b1;
    step(7); locked = 1'b0;
    step(1); locked = 1'b1;
    step(14);
    // reset asserted in STABLE, then normal sequence resumes
    a = cyc; sys_rst_n = 1'b0; locked = 1'b0;
    push(a + 1, "reset_from_run2", '0);
    step(3);
    c = cyc; sys_rst_n = 1'b1;
    push(c + 4, "stable_mmcm_release", vv(1, 0, 0, 0, 0));
    step(5); locked = 1'b1;
    step(5); sys_rst_n = 1'b0;
    push(c + 11, "reset_in_stable", '0);
    step(1);
    chk("reset_in_stable_direct", outs, '0);
    step(2);
    c = cyc; sys_rst_n = 1'b1;
    push(c + 4, "resume_mmcm_release", vv(1, 0, 0, 0, 0));
    push(c + 13, "resume_run", vv(1, 1, 1, 0, 0));
    step(16);
    // no lock: two MMCM pulses then FAULT
    a = cyc; sys_rst_n = 1'b0; locked = 1'b0;
    push(a + 1, "reset_from_run3", '0);
    step(3);
    c = cyc; sys_rst_n = 1'b1;
    push(c + 4,  "timeout_mmcm_release1", vv(1, 0, 0, 0, 0));
    push(c + 36, "timeout_retry_pulse",   vv(0, 0, 0, 0, 0));
    push(c + 40, "timeout_mmcm_release2", vv(1, 0, 0, 0, 0));
    push(c + 72, "timeout_fault",         vv(0, 0, 0, 1, 0));
    step(100);
    chk("fault_hold", outs, vv(0, 0, 0, 1, 0));
    // reset asserted in FAULT, then bring-up with lock already present
    a = cyc; sys_rst_n = 1'b0; locked = 1'b1;
    push(a + 1, "reset_in_fault", '0);
    step(1);
    chk("reset_in_fault_direct", outs, '0);
    step(2);
    c = cyc; sys_rst_n = 1'b1;
    push(c + 4, "post_fault_mmcm_release", vv(1, 0, 0, 0, 0));
    push(c + 13, "post_fault_run", vv(1, 1, 1, 0, 0));
    step(16);
    chk("post_fault_run_direct", outs, vv(1, 1, 1, 0, 0));
    step(3);
    chk("scoreboard_drained", 12'(sb.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
